// File: rtl/nand_chain_sweep.sv
// nand_chain_sweep
//
// Stimulus sequencer and checker for a three-stage cascaded NAND chain
// (e = ~(a&b), f = ~(e&c), g = ~(f&d)). On start it walks the 4-bit vector
// {a,b,c,d} through 0..15. Each vector is held for SETTLE_CYCLES+1 cycles,
// and the chain's e/f/g responses are compared against a golden model in the
// last of those cycles. The sweep reports a mismatch count, the first failing
// vector, and an overall pass flag.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset
//   start            begin a sweep; only looked at while idle
//   a, b, c, d       stimulus to the chain, vector index = {a,b,c,d}
//   e, f, g          chain responses
//   busy             sweep in progress (WAIT/SAMPLE)
//   done             one-cycle pulse when the sweep completes
//   pass             no mismatches in the last sweep (valid from done)
//   err_count        number of mismatching vectors, 0..16
//   first_fail       index of the first mismatching vector
//   first_fail_valid first_fail holds a captured index
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | stimulus held at 0, waiting for start
// WAIT    | driving vec, settle counter running down to 0
// SAMPLE  | compare e/f/g against golden, advance vec or finish
// DONE    | done pulse, pass valid, return to IDLE

module nand_chain_sweep #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail,
    output logic       first_fail_valid
);

    localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_d, done_d, pass_d, ffv_d;
    logic [4:0] err_d;
    logic [3:0] ff_d;

    logic xe, xf, xg;
    logic mismatch;

    // Golden chain evaluated on the registered vector, so the comparison
    // sees exactly what the chain is being driven with.
    assign xe       = ~(vec_q[3] & vec_q[2]);
    assign xf       = ~(xe & vec_q[1]);
    assign xg       = ~(xf & vec_q[0]);
    assign mismatch = ({e, f, g} != {xe, xf, xg});

    assign a = vec_q[3];
    assign b = vec_q[2];
    assign c = vec_q[1];
    assign d = vec_q[0];

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        err_d   = err_count;
        ff_d    = first_fail;
        ffv_d   = first_fail_valid;

        case (state_q)
            ST_IDLE: begin
                vec_d = 4'd0;
                if (start) begin
                    cnt_d   = SETTLE_RELOAD;
                    busy_d  = 1'b1;
                    err_d   = 5'd0;
                    pass_d  = 1'b0;
                    ff_d    = 4'd0;
                    ffv_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_count + 5'd1;
                    if (!first_fail_valid) begin
                        ff_d  = vec_q;
                        ffv_d = 1'b1;
                    end
                end
                if (vec_q == 4'd15) begin
                    // pass uses the count already including vector 15
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = SETTLE_RELOAD;
                    state_d = ST_WAIT;
                end
            end

            ST_DONE: begin
                vec_d   = 4'd0;
                state_d = ST_IDLE;
            end

            default: begin
                vec_d   = 4'd0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            vec_q            <= 4'd0;
            cnt_q            <= 8'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 5'd0;
            first_fail       <= 4'd0;
            first_fail_valid <= 1'b0;
        end else begin
            state_q          <= state_d;
            vec_q            <= vec_d;
            cnt_q            <= cnt_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            err_count        <= err_d;
            first_fail       <= ff_d;
            first_fail_valid <= ffv_d;
        end
    end

endmodule
